// File: rtl/reg_load_sequencer.sv
// Write-port controller for the 16-bit data register bank.
// Sequences memory loads into registers and arbitrates them against
// single-cycle ALU writebacks so no register ever gets both strobes at once.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no load in flight; accepts ld_req
// ISSUE   | one cycle: mem_rd_en pulsed with the latched address
// WAIT    | waiting for mem_rd_valid; timeout counter running
// COMMIT  | one cycle: data_in strobed into the destination, ld_done
module reg_load_sequencer #(
    parameter int NREG    = 8,
    parameter int SEL_W   = 3,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_req,
    input  logic [SEL_W-1:0]  alu_dest,
    output logic              alu_ack,
    input  logic              ld_req,
    input  logic [SEL_W-1:0]  ld_dest,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    output logic [NREG-1:0]   reg_write_en,
    output logic [NREG-1:0]   reg_mem_write_en,
    output logic [NREG-1:0]   dest_pending
);

    localparam int NSEL = 1 << SEL_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  dest_q, dest_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic              ld_busy_q, ld_busy_d;

    logic [NSEL-1:0]   ld_dec, dest_dec, alu_dec;
    logic [7:0]        cnt_inc;
    logic              alu_in_range;

    // Full-width decode; selects >= NREG fall outside the [NREG-1:0] slice
    // and therefore produce no strobe.
    function automatic logic [NSEL-1:0] onehot(input logic [SEL_W-1:0] s);
        onehot    = '0;
        onehot[s] = 1'b1;
    endfunction

    assign ld_dec       = onehot(ld_dest);
    assign dest_dec     = onehot(dest_q);
    assign alu_dec      = onehot(alu_dest);
    assign alu_in_range = |alu_dec[NREG-1:0];
    assign cnt_inc      = cnt_q + 8'd1;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dest_q     <= '0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            ld_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            ld_busy_q  <= ld_busy_d;
        end
    end

    // Load FSM: next state, latched request fields and load-side strobes.
    always_comb begin
        state_d          = state_q;
        dest_d           = dest_q;
        mem_addr_d       = mem_addr_q;
        cnt_d            = cnt_q;
        pend_d           = pend_q;
        mem_rd_en        = 1'b0;
        ld_done          = 1'b0;
        ld_err           = 1'b0;
        reg_mem_write_en = '0;

        case (state_q)
            S_IDLE: begin
                if (ld_req) begin
                    dest_d     = ld_dest;
                    mem_addr_d = ld_addr;
                    pend_d     = ld_dec[NREG-1:0];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_rd_en = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rd_valid) begin
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(TIMEOUT)) begin
                        ld_err  = 1'b1;
                        pend_d  = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_COMMIT: begin
                reg_mem_write_en = dest_dec[NREG-1:0];
                ld_done          = 1'b1;
                pend_d           = '0;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ld_busy_d = (state_d != S_IDLE);
    end

    // ALU writeback: zero latency, blocked only when it collides with the
    // register being committed this cycle (the requester retries).
    always_comb begin
        reg_write_en = '0;
        alu_ack      = 1'b0;
        if (alu_req) begin
            if (!(alu_in_range && state_q == S_COMMIT && alu_dest == dest_q)) begin
                reg_write_en = alu_dec[NREG-1:0];
                alu_ack      = 1'b1;
            end
        end
    end

    assign ld_busy      = ld_busy_q;
    assign mem_addr     = mem_addr_q;
    assign dest_pending = pend_q;

endmodule

// File: tb/tb_reg_load_sequencer.sv
// Directed bench for reg_load_sequencer with a scoreboard of expected
// output events, checked by an independent negedge monitor.
module tb_reg_load_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_req;
    logic [2:0]  alu_dest;
    logic        alu_ack;
    logic        ld_req;
    logic [2:0]  ld_dest;
    logic [15:0] ld_addr;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_err;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        mem_rd_valid;
    logic [7:0]  reg_write_en;
    logic [7:0]  reg_mem_write_en;
    logic [7:0]  dest_pending;

    reg_load_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .alu_req          (alu_req),
        .alu_dest         (alu_dest),
        .alu_ack          (alu_ack),
        .ld_req           (ld_req),
        .ld_dest          (ld_dest),
        .ld_addr          (ld_addr),
        .ld_busy          (ld_busy),
        .ld_done          (ld_done),
        .ld_err           (ld_err),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_rd_valid     (mem_rd_valid),
        .reg_write_en     (reg_write_en),
        .reg_mem_write_en (reg_mem_write_en),
        .dest_pending     (dest_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          cyc;
        logic        rd_en;
        logic        done;
        logic        err;
        logic        ack;
        logic [7:0]  we;
        logic [7:0]  mwe;
        logic [7:0]  pend;
        logic [15:0] addr;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    logic mon_en = 1'b0;
    logic [7:0] cur_pend;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h (cyc %0d)", n, act, exp, cyc);
    endtask

    task automatic push(input string n, input int c, input logic rd_en, input logic done,
                        input logic err, input logic ack, input logic [7:0] we,
                        input logic [7:0] mwe, input logic [7:0] pend, input logic [15:0] addr);
        exp_t e;
        e.name = n; e.cyc = c; e.rd_en = rd_en; e.done = done; e.err = err; e.ack = ack;
        e.we = we; e.mwe = mwe; e.pend = pend; e.addr = addr;
        sb.push_back(e);
    endtask

    // Drive a load request for one cycle; the ISSUE cycle is expected next.
    task automatic start_load(input logic [2:0] d, input logic [15:0] a);
        ld_req   = 1'b1;
        ld_dest  = d;
        ld_addr  = a;
        cur_pend = 8'd1 << d;
        push("issue", cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, cur_pend, a);
        tick();
        ld_req = 1'b0;
    endtask

    // Monitor: every cycle with any strobe/pulse active must match the next
    // scoreboard entry, including the cycle it occurs in.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && (mem_rd_en || ld_done || ld_err || alu_ack ||
                       reg_write_en != 8'h00 || reg_mem_write_en != 8'h00)) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d rd=%b done=%b err=%b ack=%b we=%b mwe=%b",
                         cyc, mem_rd_en, ld_done, ld_err, alu_ack, reg_write_en, reg_mem_write_en);
            end else begin
                e = sb.pop_front();
                if (cyc == e.cyc && mem_rd_en === e.rd_en && ld_done === e.done &&
                    ld_err === e.err && alu_ack === e.ack && reg_write_en === e.we &&
                    reg_mem_write_en === e.mwe && dest_pending === e.pend &&
                    mem_addr === e.addr && (reg_write_en & reg_mem_write_en) == 8'h00)
                    passed++;
                else
                    $display("FAIL %s got cyc=%0d rd=%b done=%b err=%b ack=%b we=%b mwe=%b pend=%b addr=%h exp cyc=%0d rd=%b done=%b err=%b ack=%b we=%b mwe=%b pend=%b addr=%h",
                             e.name, cyc, mem_rd_en, ld_done, ld_err, alu_ack, reg_write_en,
                             reg_mem_write_en, dest_pending, mem_addr, e.cyc, e.rd_en, e.done,
                             e.err, e.ack, e.we, e.mwe, e.pend, e.addr);
            end
        end
    end

    initial begin
        rst = 1'b1; alu_req = 1'b0; alu_dest = '0; ld_req = 1'b0; ld_dest = '0;
        ld_addr = '0; mem_rd_valid = 1'b0; cur_pend = '0;

        // Reset state
        tick(); tick();
        chk("rst_busy",  32'(ld_busy), 32'd0);
        chk("rst_pend",  32'(dest_pending), 32'd0);
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_pulse", 32'({mem_rd_en, ld_done, ld_err}), 32'd0);
        chk("rst_mwe",   32'(reg_mem_write_en), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // ALU write while idle
        alu_req = 1'b1; alu_dest = 3'd5;
        push("alu_idle", cyc, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 8'h00, 16'h0000);
        tick();
        alu_req = 1'b0;

        // Basic load: two empty WAIT cycles, done 5 cycles after accept
        start_load(3'd2, 16'h0040);
        chk("basic_busy", 32'(ld_busy), 32'd1);
        chk("basic_pend", 32'(dest_pending), 32'h04);
        tick(); tick(); tick();
        mem_rd_valid = 1'b1;
        push("basic_commit", cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 8'h04, 16'h0040);
        tick();
        mem_rd_valid = 1'b0;
        chk("basic_busy_commit", 32'(ld_busy), 32'd1);
        tick();
        chk("basic_busy_after", 32'(ld_busy), 32'd0);
        chk("basic_pend_after", 32'(dest_pending), 32'd0);

        // Same-register conflict in COMMIT: load wins, ALU retries
        start_load(3'd2, 16'h0100);
        tick();
        mem_rd_valid = 1'b1;
        push("conflict_commit", cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 8'h04, 16'h0100);
        tick();
        mem_rd_valid = 1'b0; alu_req = 1'b1; alu_dest = 3'd2;
        push("conflict_retry", cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 8'h00, 8'h00, 16'h0100);
        tick();
        tick();
        alu_req = 1'b0;

        // Parallel writes to different registers in COMMIT
        start_load(3'd1, 16'h0200);
        tick();
        mem_rd_valid = 1'b1;
        push("parallel", cyc + 1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 8'h02, 8'h02, 16'h0200);
        tick();
        mem_rd_valid = 1'b0; alu_req = 1'b1; alu_dest = 3'd7;
        tick();
        alu_req = 1'b0;

        // Write-after-write: ALU to pending register during WAIT, then commit
        start_load(3'd3, 16'h0300);
        tick();
        alu_req = 1'b1; alu_dest = 3'd3;
        push("waw_alu", cyc, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 8'h00, 8'h08, 16'h0300);
        tick();
        alu_req = 1'b0; mem_rd_valid = 1'b1;
        push("waw_commit", cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h08, 8'h08, 16'h0300);
        tick();
        mem_rd_valid = 1'b0;
        tick();

        // Timeout: error on the 255th WAIT cycle
        start_load(3'd4, 16'h0400);
        push("timeout_err", cyc + 255, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h10, 16'h0400);
        repeat (256) tick();
        chk("timeout_busy", 32'(ld_busy), 32'd0);
        chk("timeout_pend", 32'(dest_pending), 32'd0);

        // Valid arriving on the last WAIT cycle still commits
        start_load(3'd6, 16'h0600);
        repeat (255) tick();
        mem_rd_valid = 1'b1;
        push("late_commit", cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 8'h40, 16'h0600);
        tick();
        mem_rd_valid = 1'b0;
        tick();
        chk("late_busy", 32'(ld_busy), 32'd0);

        // ld_req while busy is ignored; reset mid-WAIT abandons the load
        start_load(3'd5, 16'h0500);
        tick();
        ld_req = 1'b1; ld_dest = 3'd6; ld_addr = 16'h0700;
        tick();
        ld_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_busy", 32'(ld_busy), 32'd0);
        chk("rstmid_pend", 32'(dest_pending), 32'd0);
        chk("rstmid_addr", 32'(mem_addr), 32'd0);
        mem_rd_valid = 1'b1;
        tick();
        mem_rd_valid = 1'b0;
        repeat (3) tick();
        chk("rstmid_busy_after", 32'(ld_busy), 32'd0);

        repeat (2) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
